// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces the board switches and push buttons for the data memory IO read port.
// Each button also gets one-cycle press/release pulses, taken from its debounced level.
module io_input_conditioner #(
    parameter int SW_WIDTH        = 10,
    parameter int BTN_WIDTH       = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SW_WIDTH-1:0]           raw_switches,
    input  logic [BTN_WIDTH-1:0]          raw_buttons,
    output logic [SW_WIDTH+BTN_WIDTH-1:0] io_input_bus,
    output logic [BTN_WIDTH-1:0]          button_press,
    output logic [BTN_WIDTH-1:0]          button_release
);

    localparam int CH    = SW_WIDTH + BTN_WIDTH;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic STABLE   = 1'b0;
    localparam logic CHANGING = 1'b1;

    logic [BTN_WIDTH-1:0] btn_level;
    logic [CH-1:0]        raw_level;
    logic [CH-1:0]        deb_vec;

    // Buttons are inverted ahead of the synchronizer, so everything downstream sees 1 = pressed.
    assign btn_level    = BTN_ACTIVE_LOW ? ~raw_buttons : raw_buttons;
    assign raw_level    = {btn_level, raw_switches};
    assign io_input_bus = deb_vec;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic                   deb_q;
        logic                   deb_d;
        logic                   state;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [CNT_W-1:0]       cnt_inc;

        // The count restarts from zero whenever sync agrees with deb again, so glitches leave nothing behind.
        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], raw_level[i]};
            state   = (sync_q[SYNC_STAGES-1] != deb_q) ? CHANGING : STABLE;
            cnt_inc = cnt_q + CNT_W'(1);
            cnt_d   = '0;
            deb_d   = deb_q;
            if (state == CHANGING) begin
                if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                    deb_d = ~deb_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
                deb_q  <= 1'b0;
                cnt_q  <= '0;
            end else begin
                sync_q <= sync_d;
                deb_q  <= deb_d;
                cnt_q  <= cnt_d;
            end
        end

        assign deb_vec[i] = deb_q;

        if (i >= SW_WIDTH) begin : g_pulse
            logic press_q;
            logic press_d;
            logic release_q;
            logic release_d;

            // Pulses are registered on the same edge that updates deb, so they line up with the bus bit.
            always_comb begin
                press_d   = deb_d & ~deb_q;
                release_d = ~deb_d & deb_q;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

            assign button_press[i-SW_WIDTH]   = press_q;
            assign button_release[i-SW_WIDTH] = release_q;
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, active-low buttons.
// Inputs change 1 ns after a rising edge; "edge k" is the k-th rising edge after that change.
module tb_io_input_conditioner;

    logic        clock;
    logic        reset;
    logic [9:0]  raw_switches;
    logic [3:0]  raw_buttons;
    logic [13:0] io_input_bus;
    logic [3:0]  button_press;
    logic [3:0]  button_release;

    int total_checks;
    int bad_checks;

    io_input_conditioner #(
        .SW_WIDTH       (10),
        .BTN_WIDTH      (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .raw_switches  (raw_switches),
        .raw_buttons   (raw_buttons),
        .io_input_bus  (io_input_bus),
        .button_press  (button_press),
        .button_release(button_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] sw, input logic [3:0] btn);
        raw_switches = sw;
        raw_buttons  = btn;
    endtask

    task automatic runEdges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset        = 1'b1;
        applyStimulus(10'h3FF, 4'b0000);
        #2 reset = 1'b0;

        // Reset state with every input active
        runEdges(3);
        checkOutput("rst_bus", 32'(io_input_bus), 32'h0);
        checkOutput("rst_press", 32'(button_press), 32'h0);
        checkOutput("rst_release", 32'(button_release), 32'h0);
        reset = 1'b1;
        runEdges(5);
        checkOutput("rst_bus_e5", 32'(io_input_bus), 32'h0);
        checkOutput("rst_press_e5", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("rst_bus_e6", 32'(io_input_bus), 32'h3FFF);
        checkOutput("rst_press_e6", 32'(button_press), 32'hF);
        checkOutput("rst_release_e6", 32'(button_release), 32'h0);
        runEdges(1);
        checkOutput("rst_press_e7", 32'(button_press), 32'h0);
        checkOutput("rst_release_e7", 32'(button_release), 32'h0);

        // Clean switch change: take switch 3 off, then back on
        applyStimulus(10'h3F7, 4'b0000);
        runEdges(6);
        checkOutput("sw_off_bus", 32'(io_input_bus), 32'h3FF7);
        checkOutput("sw_off_press", 32'(button_press), 32'h0);
        checkOutput("sw_off_release", 32'(button_release), 32'h0);
        applyStimulus(10'h3FF, 4'b0000);
        runEdges(5);
        checkOutput("sw_on_bus_e5", 32'(io_input_bus), 32'h3FF7);
        runEdges(1);
        checkOutput("sw_on_bus_e6", 32'(io_input_bus), 32'h3FFF);
        checkOutput("sw_on_press_e6", 32'(button_press), 32'h0);
        checkOutput("sw_on_release_e6", 32'(button_release), 32'h0);

        // Release all buttons
        applyStimulus(10'h3FF, 4'b1111);
        runEdges(5);
        checkOutput("rel_all_bus_e5", 32'(io_input_bus), 32'h3FFF);
        runEdges(1);
        checkOutput("rel_all_bus_e6", 32'(io_input_bus), 32'h03FF);
        checkOutput("rel_all_release_e6", 32'(button_release), 32'hF);
        checkOutput("rel_all_press_e6", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("rel_all_release_e7", 32'(button_release), 32'h0);

        // Bounce rejection on button 0: low 3, high 1, low held
        applyStimulus(10'h3FF, 4'b1110);
        runEdges(3);
        applyStimulus(10'h3FF, 4'b1111);
        runEdges(1);
        applyStimulus(10'h3FF, 4'b1110);
        runEdges(2);
        checkOutput("bounce_bus_mid", 32'(io_input_bus), 32'h03FF);
        checkOutput("bounce_press_mid", 32'(button_press), 32'h0);
        runEdges(3);
        checkOutput("bounce_bus_e5", 32'(io_input_bus), 32'h03FF);
        checkOutput("bounce_press_e5", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("bounce_bus_e6", 32'(io_input_bus), 32'h07FF);
        checkOutput("bounce_press_e6", 32'(button_press), 32'h1);
        runEdges(1);
        checkOutput("bounce_press_e7", 32'(button_press), 32'h0);

        // Press button 2, then release it
        applyStimulus(10'h3FF, 4'b1010);
        runEdges(6);
        checkOutput("b2_press_bus", 32'(io_input_bus), 32'h17FF);
        checkOutput("b2_press_pulse", 32'(button_press), 32'h4);
        runEdges(1);
        applyStimulus(10'h3FF, 4'b1110);
        runEdges(5);
        checkOutput("b2_rel_bus_e5", 32'(io_input_bus), 32'h17FF);
        checkOutput("b2_rel_release_e5", 32'(button_release), 32'h0);
        runEdges(1);
        checkOutput("b2_rel_bus_e6", 32'(io_input_bus), 32'h07FF);
        checkOutput("b2_rel_release_e6", 32'(button_release), 32'h4);
        checkOutput("b2_rel_press_e6", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("b2_rel_release_e7", 32'(button_release), 32'h0);

        // Buttons 1 and 3 pressed together
        applyStimulus(10'h3FF, 4'b0100);
        runEdges(5);
        checkOutput("simul_press_e5", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("simul_press_e6", 32'(button_press), 32'hA);
        checkOutput("simul_bus_e6", 32'(io_input_bus), 32'h2FFF);
        runEdges(1);
        checkOutput("simul_press_e7", 32'(button_press), 32'h0);

        // Release everything, then reset in the middle of a button-0 count
        applyStimulus(10'h3FF, 4'b1111);
        runEdges(7);
        checkOutput("pre_mid_bus", 32'(io_input_bus), 32'h03FF);
        applyStimulus(10'h3FF, 4'b1110);
        runEdges(4);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_bus", 32'(io_input_bus), 32'h0);
        checkOutput("mid_rst_press", 32'(button_press), 32'h0);
        checkOutput("mid_rst_release", 32'(button_release), 32'h0);
        runEdges(2);
        reset = 1'b1;
        runEdges(5);
        checkOutput("post_rst_bus_e5", 32'(io_input_bus), 32'h0);
        checkOutput("post_rst_press_e5", 32'(button_press), 32'h0);
        runEdges(1);
        checkOutput("post_rst_bus_e6", 32'(io_input_bus), 32'h07FF);
        checkOutput("post_rst_press_e6", 32'(button_press), 32'h1);
        runEdges(1);
        checkOutput("post_rst_press_e7", 32'(button_press), 32'h0);
        checkOutput("post_rst_release_e7", 32'(button_release), 32'h0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board inputs (10 slide switches, 4 push buttons) before they reach the data memory's IO read port, and drives that block's 14-bit `io_input_bus`. Every channel passes through a synchronizer and a per-channel debounce counter. The block also emits one-cycle press/release pulses for the buttons. It sits between the top-level FPGA pins and `data_memory`, in the single core clock domain.

## Interface
Parameters:
- `SW_WIDTH`, 10, number of switch channels (bus bits [SW_WIDTH-1:0]).
- `BTN_WIDTH`, 4, number of button channels (bus bits above the switches).
- `SYNC_STAGES`, 2, synchronizer flops per channel; legal values 2..3.
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required before a change is accepted; minimum 1.
- `BTN_ACTIVE_LOW`, 1, 1 = raw button pins read 0 when pressed.

Ports:
- `clock`, in, 1, core clock; the only clock.
- `reset`, in, 1, asynchronous, active-low reset.
- `raw_switches`, in, SW_WIDTH, asynchronous switch pins; 1 = on.
- `raw_buttons`, in, BTN_WIDTH, asynchronous button pins; polarity per `BTN_ACTIVE_LOW`.
- `io_input_bus`, out, SW_WIDTH+BTN_WIDTH, {debounced buttons (1 = pressed), debounced switches}; feeds `data_memory`.
- `button_press`, out, BTN_WIDTH, one-cycle pulse on a debounced 0→1 of a button.
- `button_release`, out, BTN_WIDTH, one-cycle pulse on a debounced 1→0 of a button.

## Operation
- Buttons are inverted before the synchronizer when `BTN_ACTIVE_LOW`=1. All later logic sees 1 = pressed.
- Each of the 14 channels is identical and independent:
  - synchronizer chain of `SYNC_STAGES` flops, giving `sync`;
  - debounced level `deb`;
  - counter `cnt`, width clog2(DEBOUNCE_CYCLES+1).
- Per-channel FSM, two states:
  - **STABLE** (`sync`==`deb`): `cnt` held at 0.
  - **CHANGING** (`sync`!=`deb`): `cnt` increments every cycle. When the increment reaches `DEBOUNCE_CYCLES`, `deb` toggles and `cnt` clears on the same edge; the channel returns to STABLE.
  - Any cycle in CHANGING where `sync` returns to equal `deb` clears `cnt` (a glitch is rejected). A partial count is never kept.
- `cnt` never exceeds `DEBOUNCE_CYCLES`; no wrap-around is possible.
- `io_input_bus` = {`deb` of the buttons, `deb` of the switches}, registered with no extra logic.
- Pulses:
  - `button_press[i]` is registered. It is 1 in exactly the cycle in which `deb` for button i first reads 1, and 0 in the following cycle.
  - `button_release[i]` behaves the same way for the 1→0 transition.
  - Press and release of one button can never both be asserted in the same cycle.
  - Different buttons may pulse in the same cycle.
- Reset (asserted low, any time, including mid-count):
  - synchronizer flops go to the not-pressed/off level (internal 0);
  - all `deb`, `cnt`, `io_input_bus`, `button_press` and `button_release` go to 0 immediately, without waiting for a clock.
- After reset release, an input already active must be fully re-debounced before it is reported. The press pulse then fires normally.

## Timing
- Edge numbering: the first rising edge that samples a new raw level is edge 1.
- If the raw level is held, `deb` (and the bus bit) changes on edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - Example: SYNC_STAGES=2, D=4 → changes on edge 6.
- The matching pulse is high from edge `SYNC_STAGES`+D to edge `SYNC_STAGES`+D+1.
- A raw pulse or bounce that disagrees with `deb` for fewer than D consecutive synchronized cycles produces no output change and no pulse.
- With `DEBOUNCE_CYCLES`=1, output follows `sync` with one cycle of delay; a single-cycle glitch still passes.
- Switch channels behave identically to button channels but have no pulse outputs.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and BTN_ACTIVE_LOW=1.
- **Reset state:** reset=0 with raw_buttons=4'b0000 (all pressed) and raw_switches=10'h3FF → all outputs 0 during reset. After release, `io_input_bus`=14'h3FFF on edge 6, `button_press`=4'hF for exactly one cycle, then `button_release`=0.
- **Clean switch change:** raw_switches[3] 0→1 held → `io_input_bus[3]`=1 on edge 6, not on edge 5. No pulse outputs toggle.
- **Bounce rejection:** raw_buttons[0] low for 3 cycles, high 1 cycle, then low held → no change until 6 edges after the final low; then `io_input_bus[10]`=1 and `button_press`=4'b0001 for one cycle.
- **Release pulse:** from button 2 pressed, raw_buttons[2] goes high and is held → `io_input_bus[12]`=0 and `button_release`=4'b0100 on edge 6 for one cycle. `button_press` stays 0.
- **Simultaneous channels:** buttons 1 and 3 pressed on the same edge → `button_press`=4'b1010 in a single cycle. Switch bits are unaffected.
- **Reset mid-count:** raw_buttons[0] pressed, reset asserted at edge 4 for 2 cycles, button held → outputs 0 immediately. After release, the press is reported 6 edges after the first post-reset edge with a single pulse.
